// File: rtl/bpred_pht_init_ctrl.sv
// PHT initialisation sequencer and write-port arbiter for the gshare predictor.
// Optional dropped-update counter (DropCnt) is built when BPRED_DROPCNT_EN is defined.
module bpred_pht_init_ctrl #(
    parameter int         k        = 10,
    parameter logic [1:0] INIT_VAL = 2'b01
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         PHTFlushReq,
    input  logic         StallW,
    input  logic         FlushW,
    input  logic         BranchM,
    input  logic [k-1:0] IndexM,
    input  logic [1:0]   NewBPDirPredM,
    output logic         PHTWe,
    output logic [k-1:0] PHTWa,
    output logic [1:0]   PHTWd,
    output logic         BPInitBusy,
    output logic         GHRClear,
    output logic         BPInitDone
`ifdef BPRED_DROPCNT_EN
    ,
    output logic [15:0]  DropCnt
`endif
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam logic [k-1:0] CTR_MAX  = {k{1'b1}};
    localparam logic [k-1:0] CTR_ZERO = {k{1'b0}};

    state_t       state_r, nextState_s;
    logic [k-1:0] ctr_r, nextCtr_s;
    logic         busy_r;
    logic         pipeUpd_s;
    logic         lastEntry_s;

    assign pipeUpd_s   = BranchM & ~StallW & ~FlushW;
    assign lastEntry_s = (ctr_r == CTR_MAX);

    // Next-state and write-port mux; sweep writes are gated by reset_n so the port is quiet in reset.
    always_comb begin
        nextState_s = state_r;
        nextCtr_s   = ctr_r;
        PHTWe       = 1'b0;
        PHTWa       = ctr_r;
        PHTWd       = INIT_VAL;
        BPInitDone  = 1'b0;
        case (state_r)
            CLEAR: begin
                PHTWe = reset_n;
                PHTWa = ctr_r;
                PHTWd = INIT_VAL;
                // A restart request beats the final-entry transition to IDLE.
                if (PHTFlushReq) begin
                    nextCtr_s = CTR_ZERO;
                end else if (lastEntry_s) begin
                    nextCtr_s   = CTR_ZERO;
                    nextState_s = IDLE;
                    BPInitDone  = reset_n;
                end else begin
                    nextCtr_s = ctr_r + k'(1);
                end
            end
            IDLE: begin
                PHTWe = pipeUpd_s;
                PHTWa = IndexM;
                PHTWd = NewBPDirPredM;
                if (PHTFlushReq) begin
                    nextState_s = CLEAR;
                    nextCtr_s   = CTR_ZERO;
                end else begin
                    nextCtr_s = ctr_r;
                end
            end
            default: begin
                nextState_s = CLEAR;
                nextCtr_s   = CTR_ZERO;
            end
        endcase
    end

    // State, sweep counter and registered busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= CLEAR;
            ctr_r   <= CTR_ZERO;
            busy_r  <= 1'b1;
        end else begin
            state_r <= nextState_s;
            ctr_r   <= nextCtr_s;
            busy_r  <= (nextState_s == CLEAR);
        end
    end

    assign BPInitBusy = busy_r;
    assign GHRClear   = busy_r;

`ifdef BPRED_DROPCNT_EN
    logic [15:0] dropCnt_r;

    // Saturating count of pipeline updates lost while the sweep owns the port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dropCnt_r <= 16'h0000;
        end else if ((state_r == CLEAR) && pipeUpd_s && (dropCnt_r != 16'hFFFF)) begin
            dropCnt_r <= dropCnt_r + 16'h0001;
        end else begin
            dropCnt_r <= dropCnt_r;
        end
    end

    assign DropCnt = dropCnt_r;
`endif

endmodule

// File: tb/tb_bpred_pht_init_ctrl.sv
// Self-checking bench for bpred_pht_init_ctrl (k=4) against a cycle-level behavioural model.
module tb_bpred_pht_init_ctrl;

    localparam int K     = 4;
    localparam int DEPTH = 1 << K;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         PHTFlushReq, StallW, FlushW, BranchM;
    logic [K-1:0] IndexM;
    logic [1:0]   NewBPDirPredM;
    logic         PHTWe;
    logic [K-1:0] PHTWa;
    logic [1:0]   PHTWd;
    logic         BPInitBusy, GHRClear, BPInitDone;
`ifdef BPRED_DROPCNT_EN
    logic [15:0]  DropCnt;
`endif

    int nAssert = 0;
    int nFail   = 0;

    // Model: mPos = current sweep entry, -1 when idle; mDrop = dropped-update count.
    int mPos  = 0;
    int mDrop = 0;

    bpred_pht_init_ctrl #(.k(K), .INIT_VAL(2'b01)) dut (
        .clk(clk), .reset_n(reset_n), .PHTFlushReq(PHTFlushReq), .StallW(StallW),
        .FlushW(FlushW), .BranchM(BranchM), .IndexM(IndexM), .NewBPDirPredM(NewBPDirPredM),
        .PHTWe(PHTWe), .PHTWa(PHTWa), .PHTWd(PHTWd), .BPInitBusy(BPInitBusy),
        .GHRClear(GHRClear), .BPInitDone(BPInitDone)
`ifdef BPRED_DROPCNT_EN
        , .DropCnt(DropCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setIn(input logic fl, input logic st, input logic fw, input logic br,
                         input logic [K-1:0] idx, input logic [1:0] nd);
        PHTFlushReq = fl; StallW = st; FlushW = fw; BranchM = br;
        IndexM = idx; NewBPDirPredM = nd;
    endtask

    task automatic randIn(input bit allowFlush);
        setIn(allowFlush && ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
              K'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3)));
    endtask

    // Check outputs at the falling edge, then advance the model across the rising edge.
    task automatic runCycle();
        logic upd;
        @(negedge clk);
        upd = BranchM & ~StallW & ~FlushW;
        if (!reset_n) begin
            mPos  = 0;
            mDrop = 0;
            chk("rst_we",   32'(PHTWe), 32'd0);
            chk("rst_wa",   32'(PHTWa), 32'd0);
            chk("rst_wd",   32'(PHTWd), 32'd1);
            chk("rst_busy", 32'(BPInitBusy), 32'd1);
            chk("rst_ghr",  32'(GHRClear), 32'd1);
            chk("rst_done", 32'(BPInitDone), 32'd0);
        end else if (mPos >= 0) begin
            chk("swp_we",   32'(PHTWe), 32'd1);
            chk("swp_wa",   32'(PHTWa), 32'(mPos));
            chk("swp_wd",   32'(PHTWd), 32'd1);
            chk("swp_busy", 32'(BPInitBusy), 32'd1);
            chk("swp_ghr",  32'(GHRClear), 32'd1);
            chk("swp_done", 32'(BPInitDone), 32'((mPos == DEPTH - 1) && !PHTFlushReq));
        end else begin
            chk("idl_we",   32'(PHTWe), 32'(upd));
            if (upd) begin
                chk("idl_wa", 32'(PHTWa), 32'(IndexM));
                chk("idl_wd", 32'(PHTWd), 32'(NewBPDirPredM));
            end
            chk("idl_busy", 32'(BPInitBusy), 32'd0);
            chk("idl_ghr",  32'(GHRClear), 32'd0);
            chk("idl_done", 32'(BPInitDone), 32'd0);
        end
`ifdef BPRED_DROPCNT_EN
        chk("dropcnt", 32'(DropCnt), 32'(mDrop));
`endif
        @(posedge clk);
        if (reset_n) begin
            if (mPos >= 0) begin
                if (upd && mDrop < 65535) mDrop++;
                if (PHTFlushReq)             mPos = 0;
                else if (mPos == DEPTH - 1)  mPos = -1;
                else                         mPos++;
            end else if (PHTFlushReq) begin
                mPos = 0;
            end
        end
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        setIn(1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 2'b10);
        repeat (3) runCycle();
        reset_n = 1'b1;

        // Power-up sweep with random pipeline traffic, then a few idle cycles.
        for (int i = 0; i < DEPTH + 4; i++) begin
            randIn(1'b0);
            runCycle();
        end
        chk("sweep_ended", 32'(mPos), 32'hFFFF_FFFF);

        // Directed pass-through, then the same update stalled.
        setIn(1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 2'b11); runCycle();
        setIn(1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 2'b11); runCycle();
        setIn(1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 2'b00); runCycle();

        // Flush in IDLE with a live update, then sweep with exactly three dropped updates.
        setIn(1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 2'b10); runCycle();
        for (int i = 0; i < DEPTH; i++) begin
            setIn(1'b0, 1'b0, 1'b0, (i == 2 || i == 7 || i == 13), 4'hA, 2'b11);
            runCycle();
        end
        setIn(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00); runCycle();

        // Restart request at sweep entry 10, then at the final entry.
        setIn(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00); runCycle();
        for (int i = 0; i < 10; i++) begin randIn(1'b0); runCycle(); end
        setIn(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 2'b01); runCycle();
        for (int i = 0; i < DEPTH - 1; i++) begin randIn(1'b0); runCycle(); end
        setIn(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00); runCycle();
        for (int i = 0; i < DEPTH + 2; i++) begin randIn(1'b0); runCycle(); end
        chk("restart_ended", 32'(mPos), 32'hFFFF_FFFF);

        // Reset asserted at sweep entry 7, then a fresh full sweep.
        setIn(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00); runCycle();
        for (int i = 0; i < 7; i++) begin randIn(1'b0); runCycle(); end
        reset_n = 1'b0;
        randIn(1'b0); runCycle();
        randIn(1'b0); runCycle();
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin randIn(1'b0); runCycle(); end

        // Random soak including occasional flush requests.
        for (int i = 0; i < 400; i++) begin randIn(1'b1); runCycle(); end
        setIn(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00);
        for (int i = 0; i < DEPTH + 2; i++) runCycle();
        chk("soak_ended", 32'(mPos), 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/bpred_pht_init_ctrl.md
Name: bpred_pht_init_ctrl

Overview:
- Sequencer and write-port arbiter for the gshare pattern history table (PHT).
- After reset, or on a flush request, sweeps every PHT entry to a programmable initial counter state and holds fetch prediction off while it does so.
- Outside a sweep, forwards Memory-stage direction updates from the pipeline to the PHT write port.
- Sits between the IFU branch predictor pipeline and the PHT two-port RAM; drives the GHR clear.

Parameters:
- k, 10, PHT index width; table depth is 2**k.
- INIT_VAL, 2'b01, 2-bit saturating-counter value written to every entry (weakly not-taken).

Ports:
- clk  input  1  core clock.
- reset_n  input  1  asynchronous, active-low reset.
- PHTFlushReq  input  1  single-cycle request to re-initialise the PHT (fence.i / CSR).
- StallW  input  1  Writeback stall.
- FlushW  input  1  Writeback flush.
- BranchM  input  1  Memory-stage instruction is a conditional branch.
- IndexM  input  k  PHT index of the Memory-stage branch.
- NewBPDirPredM  input  2  updated counter value for IndexM.
- PHTWe  output  1  PHT write enable (ce2 & we2 combined).
- PHTWa  output  k  PHT write address.
- PHTWd  output  2  PHT write data.
- BPInitBusy  output  1  sweep in progress; the predictor forces not-taken and holds the GHR.
- GHRClear  output  1  synchronous clear for the GHR register; same timing as BPInitBusy.
- BPInitDone  output  1  one-cycle pulse on the last sweep write.

Behaviour:
- Two states: CLEAR and IDLE. State register and sweep counter Ctr[k-1:0] are reset asynchronously.
- Reset values while reset_n=0:
  - State=CLEAR, Ctr=0.
  - BPInitBusy=1, GHRClear=1, BPInitDone=0.
  - PHTWe=0, PHTWa=0, PHTWd=INIT_VAL.
- CLEAR, every cycle with reset_n=1:
  - PHTWe=1, PHTWa=Ctr, PHTWd=INIT_VAL.
  - StallW and FlushW are ignored; the controller owns the port.
  - Ctr increments by 1, modulo 2**k.
- CLEAR end condition: when Ctr==2**k-1 is written:
  - BPInitDone=1 for that cycle.
  - Next state is IDLE; Ctr wraps to 0.
- Sweep latency: exactly 2**k cycles from reset release (or from entry to CLEAR) to the first IDLE cycle.
- BPInitBusy and GHRClear are registered: 1 in every CLEAR cycle, 0 in IDLE.
- IDLE is a combinational pass-through:
  - PHTWe = BranchM & ~StallW & ~FlushW.
  - PHTWa = IndexM, PHTWd = NewBPDirPredM.
  - Zero added latency.
- PHTFlushReq in IDLE:
  - That cycle's pipeline update is still forwarded.
  - Next state is CLEAR with Ctr=0.
- PHTFlushReq during CLEAR:
  - The sweep restarts: Ctr=0 next cycle, BPInitDone suppressed.
  - This includes the final-entry cycle; the restart wins over the transition to IDLE.
- Pipeline update (BranchM & ~StallW & ~FlushW) during CLEAR: dropped, never written.
- PHTWa/PHTWd are don't-care when PHTWe=0, except for their reset values.
- reset_n asserted mid-sweep or in IDLE: immediate return to the reset values above; a fresh full sweep starts after release.

Optional Feature:
- Macro: BPRED_DROPCNT_EN.
- Defined:
  - Adds output DropCnt [15:0].
  - Counts pipeline updates dropped during CLEAR; saturates at 16'hFFFF.
  - Reset to 0 by reset_n only; never cleared by PHTFlushReq.
- Undefined: port and counter absent; dropped updates are silently discarded.

Test Plan:
- k=4, release reset_n at cycle 0 -> PHTWe=1 with PHTWa 0..15, PHTWd=01 over 16 cycles; BPInitDone high only with PHTWa=15; BPInitBusy=0 from cycle 16.
- IDLE, BranchM=1, IndexM=4'h9, NewBPDirPredM=2'b11, StallW=0 -> same cycle PHTWe=1, PHTWa=9, PHTWd=11; repeat with StallW=1 -> PHTWe=0.
- IDLE, PHTFlushReq pulse with BranchM=1, IndexM=3 -> entry 3 written that cycle; next 16 cycles sweep 0..15, BPInitBusy=1, GHRClear=1.
- PHTFlushReq at sweep address 10 -> next PHTWa=0; total sweep 11+16 cycles; single BPInitDone at the end.
- Three BranchM updates during CLEAR (BPRED_DROPCNT_EN defined) -> no PHTWa=IndexM writes; DropCnt=3 after the sweep.
- reset_n low at sweep address 7 -> PHTWe=0 and BPInitBusy=1 immediately; after release, sweep restarts at 0.
